// File: rtl/dac_data_formatter_pkg.sv
// Shared definitions for the DAC TX formatter: ramp FSM encoding, DAC full-scale
// value and the data randomization helper shared with the RX de-randomizer.
package dac_data_formatter_pkg;

  localparam int DAC_W = 16;

  localparam logic [1:0] ST_IDLE_ENC      = 2'd0;
  localparam logic [1:0] ST_RAMP_UP_ENC   = 2'd1;
  localparam logic [1:0] ST_ACTIVE_ENC    = 2'd2;
  localparam logic [1:0] ST_RAMP_DOWN_ENC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE      = ST_IDLE_ENC,
    ST_RAMP_UP   = ST_RAMP_UP_ENC,
    ST_ACTIVE    = ST_ACTIVE_ENC,
    ST_RAMP_DOWN = ST_RAMP_DOWN_ENC
  } ramp_state_e;

  localparam logic [DAC_W-1:0] DAC_FULL_POS = 16'h7FFF;

  // Bit 0 is untouched, so applying this twice restores the word (self-inverse).
  function automatic logic [DAC_W-1:0] dac_randomize(input logic [DAC_W-1:0] x);
    return x ^ {{(DAC_W-1){x[0]}}, 1'b0};
  endfunction

endpackage

// File: rtl/dac_data_formatter_ramp_ctrl.sv
// TX enable ramp controller: IDLE/RAMP_UP/ACTIVE/RAMP_DOWN FSM with a gain counter
// that moves by one step per clock and clamps at 0 and full scale.
module dac_ramp_ctrl
  import dac_data_formatter_pkg::*;
#(
  parameter int RAMP_LOG2 = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               tx_en_i,
  output logic [RAMP_LOG2:0] gain_o,
  output logic               active_o
);

  localparam logic [RAMP_LOG2:0] GAIN_ZERO = {(RAMP_LOG2+1){1'b0}};
  localparam logic [RAMP_LOG2:0] GAIN_ONE  = {{RAMP_LOG2{1'b0}}, 1'b1};
  localparam logic [RAMP_LOG2:0] GAIN_FULL = {1'b1, {RAMP_LOG2{1'b0}}};

  ramp_state_e        state_q;
  logic [RAMP_LOG2:0] gain_q;

  // Outside IDLE the gain follows tx_en_i by +/-1 each clock, so a reversal never jumps.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      gain_q  <= GAIN_ZERO;
    end else begin
      case (state_q)
        ST_IDLE: begin
          gain_q <= GAIN_ZERO;
          if (tx_en_i) begin
            state_q <= ST_RAMP_UP;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RAMP_UP, ST_ACTIVE, ST_RAMP_DOWN: begin
          if (tx_en_i) begin
            if (gain_q >= GAIN_FULL - GAIN_ONE) begin
              gain_q  <= GAIN_FULL;
              state_q <= ST_ACTIVE;
            end else begin
              gain_q  <= gain_q + GAIN_ONE;
              state_q <= ST_RAMP_UP;
            end
          end else begin
            if (gain_q <= GAIN_ONE) begin
              gain_q  <= GAIN_ZERO;
              state_q <= ST_IDLE;
            end else begin
              gain_q  <= gain_q - GAIN_ONE;
              state_q <= ST_RAMP_DOWN;
            end
          end
        end
        default: begin
          gain_q  <= GAIN_ZERO;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign gain_o   = gain_q;
  assign active_o = (state_q != ST_IDLE);

endmodule

// File: rtl/dac_data_formatter.sv
// DAC data formatter: round/saturate the DUC sample, apply the TX gain ramp and
// optionally randomize the DAC word. Three-stage pipeline, one sample per clock.
module dac_data_formatter
  import dac_data_formatter_pkg::*;
#(
  parameter int IN_W      = 27,
  parameter int OUT_W     = 16,
  parameter int RAMP_LOG2 = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tx_en_i,
  input  logic             rand_en_i,
  input  logic [IN_W-1:0]  s_data_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  output logic [OUT_W-1:0] dac_data_o,
  output logic             dac_active_o,
  output logic             underrun_o
);

  localparam int GW     = RAMP_LOG2 + 1;
  localparam int FRAC_W = IN_W - OUT_W;

  logic [GW-1:0] gain_s;
  logic          ramp_active_s;

  dac_ramp_ctrl #(
    .RAMP_LOG2(RAMP_LOG2)
  ) u_ramp (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .tx_en_i (tx_en_i),
    .gain_o  (gain_s),
    .active_o(ramp_active_s)
  );

  logic [IN_W-1:0]         sample_s;
  logic [OUT_W-1:0]        hi_s;
  logic                    half_s;
  logic                    unused_frac_s;
  logic signed [OUT_W+GW:0] r_ext_s;
  logic signed [OUT_W+GW:0] g_ext_s;
  logic signed [OUT_W+GW:0] prod_s;
  logic [OUT_W-1:0]        s1_d, s1_q;
  logic [OUT_W-1:0]        s2_d, s2_q;
  logic [OUT_W-1:0]        dac_d, dac_q;
  logic [2:0]              act_d, act_q;
  logic                    underrun_d, underrun_q;

  assign s_ready_o = ramp_active_s;

  // Next-state logic for all three pipeline stages plus the sticky underrun flag.
  always_comb begin
    // A missing sample while ready, or any cycle in IDLE, feeds zero into the pipe.
    if (ramp_active_s && s_valid_i) begin
      sample_s = s_data_i;
    end else begin
      sample_s = {IN_W{1'b0}};
    end
    hi_s          = sample_s[IN_W-1 -: OUT_W];
    half_s        = sample_s[FRAC_W-1];
    unused_frac_s = ^sample_s[FRAC_W-2:0];

    if ((hi_s == DAC_FULL_POS) && half_s) begin
      s1_d = DAC_FULL_POS;
    end else begin
      s1_d = hi_s + {{(OUT_W-1){1'b0}}, half_s};
    end

    r_ext_s = {{(GW+1){s1_q[OUT_W-1]}}, s1_q};
    g_ext_s = {{(OUT_W+1){1'b0}}, gain_s};
    prod_s  = r_ext_s * g_ext_s;
    s2_d    = OUT_W'(prod_s >>> RAMP_LOG2);

    if (rand_en_i) begin
      dac_d = dac_randomize(s2_q);
    end else begin
      dac_d = s2_q;
    end

    act_d = {act_q[1:0], ramp_active_s};

    if (!ramp_active_s && tx_en_i) begin
      underrun_d = 1'b0;
    end else if (ramp_active_s && !s_valid_i) begin
      underrun_d = 1'b1;
    end else begin
      underrun_d = underrun_q;
    end
  end

  // Pipeline and flag registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q       <= {OUT_W{1'b0}};
      s2_q       <= {OUT_W{1'b0}};
      dac_q      <= {OUT_W{1'b0}};
      act_q      <= 3'b000;
      underrun_q <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      dac_q      <= dac_d;
      act_q      <= act_d;
      underrun_q <= underrun_d;
    end
  end

  assign dac_data_o   = dac_q;
  assign dac_active_o = act_q[2];
  assign underrun_o   = underrun_q;

endmodule

// File: tb/tb_dac_data_formatter.sv
// Scoreboard bench for dac_data_formatter (RAMP_LOG2=2): reference model pushes the
// expected word per clock, an independent monitor pops and compares on the falling edge.
`timescale 1ns/1ps
module tb_dac_data_formatter;

  localparam int RL   = 2;
  localparam int FULL = 1 << RL;
  localparam logic [26:0] D1000 = 27'h0800000;  // rounds to 16'h1000

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_en = 1'b0;
  logic        rand_en = 1'b0;
  logic        s_valid = 1'b0;
  logic [26:0] s_data = 27'd0;
  logic        s_ready, dac_active, underrun;
  logic [15:0] dac_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dac_data_formatter #(.IN_W(27), .OUT_W(16), .RAMP_LOG2(RL)) dut (
    .clk_i(clk), .rst_i(rst), .tx_en_i(tx_en), .rand_en_i(rand_en),
    .s_data_i(s_data), .s_valid_i(s_valid), .s_ready_o(s_ready),
    .dac_data_o(dac_data), .dac_active_o(dac_active), .underrun_o(underrun)
  );

  typedef struct packed {
    logic [15:0] dac;
    logic [15:0] plain;
    logic        act;
    logic        und;
    logic        rdy;
    logic        rnd;
  } exp_t;

  exp_t exp_q[$];
  int   hist_a   [0:4095];
  int   hist_g   [0:4095];
  bit   hist_idle[0:4095];
  int   cyc = 0;
  int   base = 0;
  int   m_gain = 0;
  bit   m_idle = 1'b1;
  bit   m_und = 1'b0;
  exp_t mdl_e;
  int   mdl_x;
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  // Round half up with saturation, computed as floor((v + 2^10) / 2^11).
  function automatic int round_ref(input logic [26:0] d);
    int v, r;
    v = int'($signed(d));
    r = (v + 1024) >>> 11;
    if (r > 32767) r = 32767;
    return r;
  endfunction

  // Randomizer and RX de-randomizer are the same rule: bit[i] ^= bit[0].
  function automatic logic [15:0] scramble_ref(input logic [15:0] x);
    logic [15:0] y;
    y[0] = x[0];
    for (int i = 1; i < 16; i++) y[i] = x[i] ^ x[0];
    return y;
  endfunction

  function automatic int a_at(input int k);
    return (k < base) ? 0 : hist_a[k];
  endfunction
  function automatic int g_at(input int k);
    return (k < base) ? 0 : hist_g[k];
  endfunction
  function automatic bit idle_at(input int k);
    return (k < base) ? 1'b1 : hist_idle[k];
  endfunction

  // Reference model: per clock, record history and push the word due at this edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      base   = cyc;
      m_gain = 0;
      m_idle = 1'b1;
      m_und  = 1'b0;
      exp_q.delete();
    end else begin
      hist_idle[cyc] = m_idle;
      hist_g[cyc]    = m_gain;
      hist_a[cyc]    = (!m_idle && s_valid) ? round_ref(s_data) : 0;
      mdl_x          = (a_at(cyc - 2) * g_at(cyc - 1)) >>> RL;
      mdl_e.plain    = mdl_x[15:0];
      mdl_e.rnd      = rand_en;
      mdl_e.dac      = rand_en ? scramble_ref(mdl_e.plain) : mdl_e.plain;
      mdl_e.act      = !idle_at(cyc - 2);
      if (m_idle && tx_en) m_und = 1'b0;
      else if (!m_idle && !s_valid) m_und = 1'b1;
      if (m_idle) begin
        if (tx_en) m_idle = 1'b0;
      end else if (tx_en) begin
        m_gain = (m_gain + 1 > FULL) ? FULL : m_gain + 1;
      end else if (m_gain <= 1) begin
        m_gain = 0;
        m_idle = 1'b1;
      end else begin
        m_gain = m_gain - 1;
      end
      mdl_e.und = m_und;
      mdl_e.rdy = !m_idle;
      exp_q.push_back(mdl_e);
      cyc++;
    end
  end

  // Monitor: compare every word the DUT presents against the scoreboard.
  always @(negedge clk) begin
    if (!rst && exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("dac_data", dac_data, mon_e.dac);
      check("dac_active", dac_active, mon_e.act);
      check("underrun", underrun, mon_e.und);
      check("s_ready", s_ready, mon_e.rdy);
      if (mon_e.rnd) check("derand", scramble_ref(dac_data), mon_e.plain);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic directed_three(input string tag, input logic [26:0] din [3],
                                input logic [15:0] dexp [3]);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k >= 3) check(tag, dac_data, dexp[k-3]);
      s_data = (k < 3) ? din[k] : D1000;
    end
  endtask

  logic [15:0] up_exp  [8] = '{16'h0000, 16'h0000, 16'h0000, 16'h0400,
                               16'h0800, 16'h0C00, 16'h1000, 16'h1000};
  logic        up_act  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [15:0] rev_exp [8] = '{16'h0400, 16'h0800, 16'h0C00, 16'h0800,
                               16'h0400, 16'h0800, 16'h0C00, 16'h1000};
  logic [26:0] rs_in   [3] = '{27'h0000400, 27'h3FFFFFF, 27'h4000000};
  logic [15:0] rs_exp  [3] = '{16'h0001, 16'h7FFF, 16'h8000};
  logic [26:0] rd_in   [3] = '{27'h0001800, 27'h0001000, 27'h0000C00};
  logic [15:0] rd_exp  [3] = '{16'hFFFD, 16'h0002, 16'h0002};

  initial begin
    repeat (3) @(negedge clk);
    check("rst_dac", dac_data, 16'h0000);
    check("rst_active", dac_active, 1'b0);
    check("rst_ready", s_ready, 1'b0);
    check("rst_underrun", underrun, 1'b0);
    rst = 1'b0;
    s_valid = 1'b1;
    s_data = D1000;
    repeat (3) @(negedge clk);

    // Ramp up from IDLE with constant r=16'h1000.
    tx_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("rampup_dac", dac_data, up_exp[k]);
      check("rampup_active", dac_active, up_act[k]);
    end

    directed_three("round_sat", rs_in, rs_exp);
    rand_en = 1'b1;
    directed_three("randomize", rd_in, rd_exp);
    rand_en = 1'b0;

    // Random traffic with occasional tx_en flips and a burst of per-clock toggling.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      s_data  = 27'($urandom);
      s_valid = ($urandom_range(0, 7) != 0);
      rand_en = 1'($urandom_range(0, 1));
      if (i >= 150 && i < 170) tx_en = ~tx_en;
      else if ($urandom_range(0, 15) == 0) tx_en = ~tx_en;
    end

    @(negedge clk);
    tx_en = 1'b0;
    rand_en = 1'b0;
    s_valid = 1'b1;
    s_data = D1000;
    repeat (12) @(negedge clk);
    check("idle_ready", s_ready, 1'b0);

    // Ramp reversal: drop tx_en at gain 3, re-raise at gain 1.
    tx_en = 1'b1;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      check("reversal_ready", s_ready, 1'b1);
      if (k >= 3) check("reversal_dac", dac_data, rev_exp[k-3]);
      if (k == 3) tx_en = 1'b0;
      if (k == 5) tx_en = 1'b1;
    end

    // Underrun: two missing samples in ACTIVE.
    check("underrun_clear", underrun, 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k >= 1) check("underrun_sticky", underrun, 1'b1);
      if (k == 3 || k == 4) check("underrun_zero", dac_data, 16'h0000);
      if (k >= 5) check("underrun_resume", dac_data, 16'h1000);
      s_valid = (k >= 2);
    end
    tx_en = 1'b0;
    repeat (8) @(negedge clk);
    check("underrun_idle", underrun, 1'b1);
    tx_en = 1'b1;
    @(negedge clk);
    check("underrun_restart", underrun, 1'b0);
    repeat (6) @(negedge clk);

    // Async reset in ACTIVE with underrun set, mid-cycle.
    s_valid = 1'b0;
    @(negedge clk);
    s_valid = 1'b1;
    repeat (5) @(negedge clk);
    check("pre_reset_active", dac_active, 1'b1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    tx_en = 1'b0;
    #1;
    check("async_dac", dac_data, 16'h0000);
    check("async_active", dac_active, 1'b0);
    check("async_ready", s_ready, 1'b0);
    check("async_underrun", underrun, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("post_reset_dac", dac_data, 16'h0000);
      check("post_reset_ready", s_ready, 1'b0);
    end
    tx_en = 1'b1;
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dac_data_formatter.md
Name: dac_data_formatter

Overview:
- TX-side counterpart of the ADC capture path. Turns the 27-bit TX sample stream from the DUC into 16-bit two's-complement DAC words.
- Processing chain: round/saturate, apply a click-free gain ramp on TX enable and disable, then optionally apply DAC data randomization (bit[i] ^= bit[0]).
- The randomization is the exact inverse of the receive de-randomizer.
- Sits between the DUC output and the DAC pin register, in the DAC clock domain, at one sample per clock.

Parameters:
- IN_W, 27, input sample width (two's complement).
- OUT_W, 16, DAC word width.
- RAMP_LOG2, 8, ramp length exponent. Full-scale gain is 2^RAMP_LOG2; a full ramp lasts 2^RAMP_LOG2 clocks.

Ports:
- clk_i  in  1  DAC sample clock.
- rst_i  in  1  asynchronous, active-high reset.
- tx_en_i  in  1  transmit request, level-sensitive.
- rand_en_i  in  1  1 = randomize the DAC output word, sampled in stage 3.
- s_data_i  in  IN_W  TX sample.
- s_valid_i  in  1  s_data_i is valid.
- s_ready_o  out  1  block accepts a sample this cycle.
- dac_data_o  out  OUT_W  DAC word, registered.
- dac_active_o  out  1  dac_data_o carries ramped/active signal, aligned with dac_data_o.
- underrun_o  out  1  sticky: valid was low while ready was high.

Behaviour:
- Reset (async, all registers): state=IDLE, gain=0, all pipeline stages 0.
  - dac_data_o=0, dac_active_o=0, s_ready_o=0, underrun_o=0.
- FSM states: IDLE, RAMP_UP, ACTIVE, RAMP_DOWN. Gain counter width is RAMP_LOG2+1.
  - IDLE: gain=0. tx_en_i=1 -> RAMP_UP.
  - RAMP_UP: gain+1 per clock. On reaching 2^RAMP_LOG2 -> ACTIVE. tx_en_i=0 -> RAMP_DOWN, continuing from the current gain (no jump).
  - ACTIVE: gain held at 2^RAMP_LOG2. tx_en_i=0 -> RAMP_DOWN.
  - RAMP_DOWN: gain-1 per clock. On reaching 0 -> IDLE. tx_en_i=1 -> RAMP_UP from the current gain.
- s_ready_o = (state != IDLE), combinational from the state register. A transfer occurs when s_valid_i & s_ready_o.
- Sample insertion: if s_ready_o=1 and s_valid_i=0, the pipeline takes sample 0 and underrun_o is set.
  - underrun_o clears only on reset, or on the first clock of an IDLE->RAMP_UP transition.
  - In IDLE the pipeline takes 0, with no underrun.
- Stage 1, round/saturate:
  - r = s_data_i[26:11] + s_data_i[10] (round half up).
  - If s_data_i[26:11]==16'h7FFF and s_data_i[10]==1, output 16'h7FFF (saturate).
  - The negative side cannot overflow.
- Stage 2, gain: p = r * gain (signed 16 x unsigned RAMP_LOG2+1), then arithmetic shift right by RAMP_LOG2.
  - Gain 2^RAMP_LOG2 is an exact pass-through; gain 0 gives 0.
  - The gain used is the value registered in the same cycle the sample enters stage 2.
- Stage 3, randomize:
  - If rand_en_i: out[0]=x[0], out[i]=x[i]^x[0] for i=1..15.
  - Otherwise out=x.
- Latency: 3 clocks from a transfer at s_data_i to dac_data_o.
- dac_active_o: (state != IDLE) delayed 3 clocks.
- Ramp-down into IDLE: in-flight samples drain naturally. The last non-zero word is the one carried at gain=1.
- Reset mid-ramp: output goes to 0 immediately (async). This click is acceptable.
- tx_en_i toggling every clock: gain oscillates by ±1 and never under- or overflows. The counter clamps at 0 and at 2^RAMP_LOG2.

Decomposition:
- Shared package holds:
  - localparams for the FSM state encoding (2 bits: IDLE=0, RAMP_UP=1, ACTIVE=2, RAMP_DOWN=3);
  - DAC_FULL_POS=16'h7FFF;
  - a randomize function used by this block and reusable by the RX de-randomizer (the operation is self-inverse).
- One natural sub-module, dac_ramp_ctrl: the FSM plus gain counter, with outputs gain and active.
- Round, gain and randomize stay inline as pipeline stages.

Test Plan (RAMP_LOG2=2 in bench unless stated):
- Round/saturate, tx_en_i held 1 until ACTIVE, rand_en_i=0:
  - s_data_i=27'h0000400 -> dac_data_o=16'h0001 three clocks later;
  - 27'h3FFFFFF -> 16'h7FFF;
  - 27'h4000000 -> 16'h8000.
- Randomize: ACTIVE, rand_en_i=1.
  - Input 27'h0001800 (r=16'h0003) -> 16'hFFFD.
  - Input 27'h0001000 (r=16'h0002) -> 16'h0002.
  - Feeding the output through the RX de-randomizer restores the original value.
- Ramp up, constant input r=16'h1000:
  - Starting from IDLE, raise tx_en_i; output sequence is 0, 16'h0400, 16'h0800, 16'h0C00, 16'h1000, then steady.
  - dac_active_o rises with the first ramped word.
- Ramp reversal:
  - Drop tx_en_i when gain=3 (RAMP_UP), re-raise it at gain=1.
  - Gain sequence 3,2,1,2,3,4, with no jumps; state never enters IDLE.
- Underrun: in ACTIVE, deassert s_valid_i for 2 clocks.
  - Two 16'h0000 words appear 3 clocks later and underrun_o=1.
  - underrun_o stays 1 through ACTIVE; a new IDLE->RAMP_UP clears it.
- Async reset in ACTIVE, mid-clock:
  - dac_data_o, dac_active_o, s_ready_o and underrun_o go to 0 before the next edge.
  - After release, the block stays IDLE with output 0 until tx_en_i=1.
